// File: rtl/rx_sequencer.sv
// UART 8N1 receive sequencer with byte FIFO and valid/ready output.
// Define RX_PARITY_EN for start, 8 data, even parity, stop framing.
module rx_sequencer #(
  parameter int CLKS_PER_BIT = 4800,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataIn,
  input  logic       Enable,
  output logic [7:0] DataOut,
  output logic       DataValid,
  input  logic       DataReady,
  output logic       FrameErr,
  output logic       Overrun,
`ifdef RX_PARITY_EN
  output logic       ParityErr,
`endif
  output logic       Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] ONE = (AW + 1)'(1);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
  } state_t;
`endif

  state_t state, state_n;
  logic meta, sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic push_pend, push_n;
  logic [7:0] push_data;
  logic ferr_n;
`ifdef RX_PARITY_EN
  logic pbad, pbad_n;
  logic perr_n;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= DataIn;
      sync <= meta;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    push_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef RX_PARITY_EN
    pbad_n  = pbad;
    perr_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef RX_PARITY_EN
        pbad_n = 1'b0;
`endif
        if (Enable && !sync) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n = '0;
          sh_n  = {sync, sh[7:1]};
          idx_n = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          pbad_n  = (^sh) != sync;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == LAST) begin
          cnt_n = '0;
`ifdef RX_PARITY_EN
          perr_n = pbad;
`endif
          if (sync) begin
            state_n = IDLE;
`ifdef RX_PARITY_EN
            push_n = !pbad;
`else
            push_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_n = '0;
        if (sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Disable abandons the frame silently; FIFO side is untouched
    if (!Enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      push_n  = 1'b0;
      ferr_n  = 1'b0;
`ifdef RX_PARITY_EN
      perr_n  = 1'b0;
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
      FrameErr  <= 1'b0;
`ifdef RX_PARITY_EN
      pbad      <= 1'b0;
      ParityErr <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      push_pend <= push_n;
      push_data <= sh_n;
      FrameErr  <= ferr_n;
`ifdef RX_PARITY_EN
      pbad      <= pbad_n;
      ParityErr <= perr_n;
`endif
    end
  end

  assign Busy = (state != IDLE);

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr, rd, rd_inc, used;
  logic empty, full, pop, push_ok;

  assign rd_inc  = rd + ONE;
  assign used    = wr - rd;
  assign empty   = (wr == rd);
  assign full    = (wr[AW] != rd[AW]) &&
                   (wr[AW-1:0] == rd[AW-1:0]);
  assign pop     = DataValid && DataReady;
  assign push_ok = push_pend && (!full || pop);
  assign Overrun = push_pend && full && !pop;
  assign DataValid = !empty;

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr[AW-1:0]] <= push_data;
  end

  // DataOut holds the head so it is a plain register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr      <= '0;
      rd      <= '0;
      DataOut <= '0;
    end else begin
      if (push_ok) wr <= wr + ONE;
      if (pop) rd <= rd_inc;
      if (pop) begin
        if (used > ONE) DataOut <= mem[rd_inc[AW-1:0]];
        else if (push_ok) DataOut <= push_data;
      end else if (push_ok && empty) begin
        DataOut <= push_data;
      end
    end
  end

endmodule

// File: tb/tb_rx_sequencer.sv
// Scoreboard bench for rx_sequencer: frame-level reference model,
// directed corner cases plus randomized frames.
module tb_rx_sequencer;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int TDV = 2 + CPB / 2 + (PAR ? 10 : 9) * CPB + 1;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic DataIn = 1'b1;
  logic Enable = 1'b0;
  logic DataReady = 1'b0;
  logic [7:0] DataOut;
  logic DataValid, FrameErr, Overrun, Busy;
`ifdef RX_PARITY_EN
  logic ParityErr;
`endif

  rx_sequencer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .DataIn(DataIn),
    .Enable(Enable),
    .DataOut(DataOut),
    .DataValid(DataValid),
    .DataReady(DataReady),
    .FrameErr(FrameErr),
    .Overrun(Overrun),
`ifdef RX_PARITY_EN
    .ParityErr(ParityErr),
`endif
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0, busy_hi = 0;
  int ferr_exp = 0, ovr_exp = 0, perr_exp = 0;
  logic [7:0] q[$];
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and checks every handshake against the queue
  initial forever begin
    @(negedge Clock);
    if (Reset) begin
      if (FrameErr) ferr_cnt++;
      if (Overrun) ovr_cnt++;
`ifdef RX_PARITY_EN
      if (ParityErr) perr_cnt++;
`endif
      if (Busy) busy_hi++;
      if (DataValid && DataReady) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL pop actual %02h required none", DataOut);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          if (DataOut !== e) begin
            errors++;
            $display("FAIL pop actual %02h required %02h", DataOut, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
    if (rand_ready) DataReady = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bit(input logic b);
    DataIn = b;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (PAR) send_bit((^b) ^ flip);
    send_bit(stop);
  endtask

  // Reference: what a frame should produce, decided before it is sent
  task automatic expect_frame(input logic [7:0] b, input logic stop,
                              input logic flip);
    if (!stop) begin
      ferr_exp++;
      if (PAR && flip) perr_exp++;
    end else if (PAR && flip) begin
      perr_exp++;
    end else if (q.size() >= DEPTH && !rand_ready && !DataReady) begin
      ovr_exp++;
    end else begin
      q.push_back(b);
    end
  endtask

  task automatic drain();
    DataReady = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic stop, flip;
    int fc, qs;

    repeat (5) tick();
    chk("rst_dataout", DataOut, 0);
    chk("rst_valid", DataValid, 0);
    chk("rst_ferr", FrameErr, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b1;
    Enable = 1'b1;
    repeat (10000) tick();
    chk("idle_busy_cnt", busy_hi, 0);
    chk("idle_valid", DataValid, 0);
    chk("idle_dataout", DataOut, 0);

    // 0x55 with exact DataValid latency, then a one-cycle pop
    expect_frame(8'h55, 1'b1, 1'b0);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
      begin
        @(posedge Clock);
        repeat (TDV - 1) @(posedge Clock);
        #1 chk("valid_before", DataValid, 0);
        @(posedge Clock);
        #1 chk("valid_at", DataValid, 1);
        chk("dataout_55", DataOut, 8'h55);
      end
    join
    DataReady = 1'b1;
    tick();
    DataReady = 1'b0;
    chk("valid_after_pop", DataValid, 0);

    // Framing error with break, then a good frame
    DataReady = 1'b1;
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("busy_in_break", Busy, 1);
    chk("ferr_break", ferr_cnt, ferr_exp);
    DataIn = 1'b1;
    repeat (4) tick();
    chk("busy_after_break", Busy, 0);
    expect_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    repeat (4) tick();
    chk("a3_drained", q.size(), 0);

    // Short glitch aborts in START
    DataReady = 1'b0;
    fc = ferr_cnt;
    DataIn = 1'b0;
    repeat (4) tick();
    chk("glitch_busy", Busy, 1);
    DataIn = 1'b1;
    repeat (CPB) tick();
    chk("glitch_idle", Busy, 0);
    chk("glitch_valid", DataValid, 0);
    chk("glitch_ferr", ferr_cnt, fc);

    // Overrun on fifth frame, in-order drain
    for (int k = 1; k <= 5; k++) begin
      expect_frame(8'(k), 1'b1, 1'b0);
      send_frame(8'(k), 1'b1, 1'b0);
    end
    repeat (2) tick();
    chk("overrun_cnt", ovr_cnt, ovr_exp);
    chk("full_valid", DataValid, 1);
    drain();

    // Enable drop mid-frame
    DataReady = 1'b0;
    fc = ferr_cnt;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    repeat (CPB / 2) tick();
    Enable = 1'b0;
    tick();
    chk("en_busy", Busy, 0);
    DataIn = 1'b1;
    repeat (10 * CPB) tick();
    Enable = 1'b1;
    repeat (4) tick();
    chk("en_nopush", DataValid, 0);
    chk("en_noerr", ferr_cnt, fc);

`ifdef RX_PARITY_EN
    expect_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) tick();
    chk("parity_err", perr_cnt, perr_exp);
    chk("parity_nopush", DataValid, 0);
`endif

    // Randomized frames, glitches and consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        DataIn = 1'b0;
        repeat ($urandom_range(1, CPB / 2 - 4)) tick();
        DataIn = 1'b1;
        repeat (CPB) tick();
      end
      b = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      flip = PAR && ($urandom_range(0, 3) == 0);
      expect_frame(b, stop, flip);
      send_frame(b, stop, flip);
      if (!stop) begin
        repeat ($urandom_range(0, 2)) send_bit(1'b0);
        DataIn = 1'b1;
        repeat (4) tick();
      end
      repeat ($urandom_range(0, 20)) tick();
    end
    rand_ready = 1'b0;
    drain();
    chk("rand_ferr", ferr_cnt, ferr_exp);
    chk("rand_perr", perr_cnt, perr_exp);
    chk("rand_ovr", ovr_cnt, ovr_exp);

    // Asynchronous reset mid-frame empties the FIFO
    DataReady = 1'b0;
    expect_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    qs = q.size();
    chk("pre_rst_valid", DataValid, qs > 0 ? 1 : 0);
    DataIn = 1'b0;
    repeat (3 * CPB) tick();
    #2 Reset = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_valid", DataValid, 0);
    chk("arst_dataout", DataOut, 0);
    q.delete();
    DataIn = 1'b1;
    tick();
    Reset = 1'b1;
    repeat (4) tick();
    chk("post_rst_valid", DataValid, 0);
    chk("final_ferr", ferr_cnt, ferr_exp);
    chk("final_ovr", ovr_cnt, ovr_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
